// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory sequencer of the MIPS core:
// access-size encodings, the sequencer state type and the alignment rule.
package mips_mem_pkg;

   // Access size field carried in EX/MEM (2'b11 is handled as a word)
   localparam logic [1:0] BHW_BYTE = 2'b00;
   localparam logic [1:0] BHW_HALF = 2'b01;
   localparam logic [1:0] BHW_WORD = 2'b10;

   // Wait counter width, wide enough for the largest legal timeout (1023)
   localparam int CNT_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   // Halves must sit on even addresses, words (and the 2'b11 alias) on
   // multiples of four; bytes are always aligned.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (size)
         BHW_BYTE: bad = 1'b0;
         BHW_HALF: bad = offset[0];
         default:  bad = (offset != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between the 32-bit little-endian data bus and
// the core: byte enables plus replicated store data on the way out, lane
// selection plus sign/zero extension on the way back.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  st_size_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_data_o,
   input  logic [1:0]  ld_size_i,
   input  logic [1:0]  ld_off_i,
   input  logic        ld_sign_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [7:0]  ldByte;
   logic [15:0] ldHalf;

   // Store side: pick byte enables for the addressed lanes and replicate the
   // low bits of the store data across the word so any lane sees them.
   always_comb begin
      st_be_o   = 4'b1111;
      st_data_o = st_data_i;
      case (st_size_i)
         BHW_BYTE: begin
            st_be_o   = 4'b0001 << st_off_i;
            st_data_o = {4{st_data_i[7:0]}};
         end
         BHW_HALF: begin
            st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
            st_data_o = {2{st_data_i[15:0]}};
         end
         default: begin
            st_be_o   = 4'b1111;
            st_data_o = st_data_i;
         end
      endcase
   end

   // Load side: select the addressed byte or half lane of the returned word,
   // then widen it to 32 bits with either sign or zero fill.
   always_comb begin
      case (ld_off_i)
         2'd0:    ldByte = ld_rdata_i[7:0];
         2'd1:    ldByte = ld_rdata_i[15:8];
         2'd2:    ldByte = ld_rdata_i[23:16];
         default: ldByte = ld_rdata_i[31:24];
      endcase
      ldHalf = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
      case (ld_size_i)
         BHW_BYTE: ld_data_o = {{24{ld_sign_i & ldByte[7]}}, ldByte};
         BHW_HALF: ld_data_o = {{16{ld_sign_i & ldHalf[15]}}, ldHalf};
         default:  ld_data_o = ld_rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: validates the EX/MEM memory request, runs one req/ack
// transaction on the data bus with a wait timeout, stalls the pipeline while
// the transaction is outstanding and hands aligned load data to MEM/WB.
module mem_stage_ctrl
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  bhw,
   input  logic        ext_sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        align_err,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   // Counter value seen in the last BUSY cycle the bus is allowed to take
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   mem_state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_we_q;
   logic [31:0]      bus_addr_q;
   logic [3:0]       bus_be_q;
   logic [31:0]      bus_wdata_q;
   logic [1:0]       size_q;
   logic             sign_q;
   logic [1:0]       off_q;
   logic [31:0]      load_data_q;
   logic             timeout_q;

   logic             accessReq;
   logic             illegalReq;
   logic             startAccess;
   logic             timeoutHit;
   logic [3:0]       stBe;
   logic [31:0]      stData;
   logic [31:0]      ldData;

   // A request is refused when both directions are asked for at once or when
   // the address does not fit the access size.
   assign accessReq   = mem_read | mem_write;
   assign illegalReq  = (mem_read & mem_write) | isMisaligned(bhw, addr[1:0]);
   assign startAccess = (state_q == IDLE) & accessReq & ~illegalReq;
   assign timeoutHit  = (state_q == BUSY) & ~bus_ack & (cnt_q == CNT_LAST);

   // Store lanes come straight from EX/MEM; load extraction uses the size,
   // offset and sign captured when the access was launched.
   mem_lane_align u_lane_align (
      .st_size_i  (bhw),
      .st_off_i   (addr[1:0]),
      .st_data_i  (wdata),
      .st_be_o    (stBe),
      .st_data_o  (stData),
      .ld_size_i  (size_q),
      .ld_off_i   (off_q),
      .ld_sign_i  (sign_q),
      .ld_rdata_i (bus_rdata),
      .ld_data_o  (ldData)
   );

   // State register; reset abandons any access in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and wait counter: ack wins over a timeout in the same cycle,
   // and DONE always falls back to IDLE so the stale EX/MEM request is ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (startAccess) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus_ack || (cnt_q == CNT_LAST)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Outputs per state; the combinational IDLE outputs are forced low while
   // reset is held so nothing leaks out of a design that is being reset.
   always_comb begin
      stall      = 1'b0;
      bus_req    = 1'b0;
      load_valid = 1'b0;
      bus_err    = 1'b0;
      align_err  = 1'b0;
      case (state_q)
         IDLE: begin
            stall     = rst & startAccess;
            align_err = rst & accessReq & illegalReq;
         end
         BUSY: begin
            stall   = 1'b1;
            bus_req = 1'b1;
         end
         DONE: begin
            load_valid = ~bus_we_q & ~timeout_q;
            bus_err    = timeout_q;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   // Transaction registers: bus fields are frozen at launch, load data is
   // captured on ack (reads only) and cleared when the bus times out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         size_q      <= BHW_BYTE;
         sign_q      <= 1'b0;
         off_q       <= 2'b00;
         load_data_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (startAccess) begin
            bus_we_q    <= mem_write;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_be_q    <= stBe;
            bus_wdata_q <= stData;
            size_q      <= bhw;
            sign_q      <= ext_sign;
            off_q       <= addr[1:0];
            timeout_q   <= 1'b0;
         end
         if ((state_q == BUSY) && bus_ack && !bus_we_q) begin
            load_data_q <= ldData;
         end
         if (timeoutHit) begin
            timeout_q   <= 1'b1;
            load_data_q <= '0;
         end
      end
   end

   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;
   assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: drives EX/MEM requests, plays the data-memory
// slave with a configurable ack delay, and matches every completion pulse
// against a queue of expected events.
module tb_mem_stage_ctrl;
   import mips_mem_pkg::*;

   localparam int TIMEOUT = 4;
   localparam int EV_LOAD   = 1;
   localparam int EV_ALIGN  = 2;
   localparam int EV_BUSERR = 3;
   localparam int NO_ACK    = -1;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  bhw;
   logic        ext_sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        align_err;
   logic        bus_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } expEvent_t;

   expEvent_t sbQ[$];
   expEvent_t monEv;
   int assertCount = 0;
   int failCount   = 0;

   mem_stage_ctrl #(.TIMEOUT_CYC(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .bhw        (bhw),
      .ext_sign   (ext_sign),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .align_err  (align_err),
      .bus_err    (bus_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata)
   );

   // Free-running core clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus itself ever wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference lane extraction written as a shift of the whole word
   function automatic logic [31:0] refLoad(input logic [1:0] size, input logic [1:0] off,
                                           input logic sgn, input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (size)
         2'b00:   return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
         2'b01:   return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] refBe(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   // Completion monitor: each pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst && (load_valid || align_err || bus_err)) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedEvent", {29'd0, load_valid, align_err, bus_err}, 32'd0);
         end else begin
            monEv = sbQ.pop_front();
            checkOutput("evLoadValid", 32'(load_valid), 32'(monEv.kind == EV_LOAD));
            checkOutput("evAlignErr", 32'(align_err), 32'(monEv.kind == EV_ALIGN));
            checkOutput("evBusErr", 32'(bus_err), 32'(monEv.kind == EV_BUSERR));
            if (monEv.kind != EV_ALIGN) begin
               checkOutput("evLoadData", load_data, monEv.data);
            end
         end
      end
   end

   // Present one request (called just after a rising edge), act as the bus
   // slave, count stall and request cycles up to the first non-stalled cycle.
   task automatic applyStimulus(
      input string       tag,
      input logic        rd,
      input logic        wr,
      input logic [1:0]  size,
      input logic        sgn,
      input logic [31:0] a,
      input logic [31:0] wd,
      input logic [31:0] rword,
      input int          ackWait,
      input int          expKind,
      input logic [31:0] expData,
      input logic [3:0]  expBe,
      input logic [31:0] expWdata,
      input int          expStall,
      input int          expReq
   );
      int stallCnt;
      int reqCnt;
      int cyc;
      bit done;
      stallCnt = 0;
      reqCnt   = 0;
      cyc      = 0;
      done     = 1'b0;
      mem_read  = rd;
      mem_write = wr;
      bhw       = size;
      ext_sign  = sgn;
      addr      = a;
      wdata     = wd;
      if (expKind != 0) begin
         sbQ.push_back('{expKind, expData});
      end
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus_ack   = 1'b0;
         bus_rdata = ~rword;
         if (stall) stallCnt++;
         if (bus_req) begin
            reqCnt++;
            checkOutput({tag, ".bus_we"}, 32'(bus_we), 32'(wr));
            checkOutput({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
            checkOutput({tag, ".bus_be"}, 32'(bus_be), 32'(expBe));
            checkOutput({tag, ".bus_wdata"}, bus_wdata, expWdata);
            if (ackWait >= 0 && reqCnt == ackWait + 1) begin
               bus_ack   = 1'b1;
               bus_rdata = rword;
            end
         end
         if (!stall && !bus_req) done = 1'b1;
      end
      checkOutput({tag, ".cycleBound"}, 32'(done), 32'd1);
      checkOutput({tag, ".stallCycles"}, 32'(stallCnt), 32'(expStall));
      checkOutput({tag, ".reqCycles"}, 32'(reqCnt), 32'(expReq));
      @(posedge clk);
      #1;
      bus_ack   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   initial begin
      logic [1:0]  sz;
      logic [1:0]  off;
      logic        sg;
      logic [31:0] w;
      logic [31:0] a;
      int          aw;

      rst       = 1'b0;
      mem_read  = 1'b1;
      mem_write = 1'b0;
      bhw       = BHW_WORD;
      ext_sign  = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;

      // Reset state, with a legal and then an illegal request visible
      repeat (2) @(negedge clk);
      checkOutput("reset.stall", 32'(stall), 32'd0);
      checkOutput("reset.bus_req", 32'(bus_req), 32'd0);
      checkOutput("reset.load_valid", 32'(load_valid), 32'd0);
      checkOutput("reset.bus_err", 32'(bus_err), 32'd0);
      checkOutput("reset.load_data", load_data, 32'd0);
      checkOutput("reset.bus_be", 32'(bus_be), 32'd0);
      mem_write = 1'b1;
      #1;
      checkOutput("reset.align_err", 32'(align_err), 32'd0);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed accesses");
      applyStimulus("storeWord", 1'b0, 1'b1, BHW_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0,
                    0, 32'h0, 4'b1111, 32'hDEADBEEF, 2, 1);
      applyStimulus("loadByteS", 1'b1, 1'b0, BHW_BYTE, 1'b1, 32'h203, 32'h0, 32'h80FF1234, 0,
                    EV_LOAD, 32'hFFFFFF80, 4'b1000, 32'h0, 2, 1);
      applyStimulus("loadByteU", 1'b1, 1'b0, BHW_BYTE, 1'b0, 32'h203, 32'h0, 32'h80FF1234, 0,
                    EV_LOAD, 32'h00000080, 4'b1000, 32'h0, 2, 1);
      applyStimulus("loadHalfU", 1'b1, 1'b0, BHW_HALF, 1'b0, 32'h206, 32'h0, 32'h80010000, 3,
                    EV_LOAD, 32'h00008001, 4'b1100, 32'h0, 5, 4);
      applyStimulus("misWord", 1'b1, 1'b0, BHW_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 0,
                    EV_ALIGN, 32'h0, 4'b0000, 32'h0, 0, 0);
      applyStimulus("rdAndWr", 1'b1, 1'b1, BHW_WORD, 1'b0, 32'h100, 32'h0, 32'h0, 0,
                    EV_ALIGN, 32'h0, 4'b0000, 32'h0, 0, 0);
      applyStimulus("misHalf", 1'b0, 1'b1, BHW_HALF, 1'b0, 32'h201, 32'h0, 32'h0, 0,
                    EV_ALIGN, 32'h0, 4'b0000, 32'h0, 0, 0);
      applyStimulus("storeByte", 1'b0, 1'b1, BHW_BYTE, 1'b0, 32'h101, 32'h000000A5, 32'h0, 1,
                    0, 32'h0, 4'b0010, 32'hA5A5A5A5, 3, 2);
      applyStimulus("storeHalf", 1'b0, 1'b1, BHW_HALF, 1'b0, 32'h202, 32'h1234BEEF, 32'h0, 0,
                    0, 32'h0, 4'b1100, 32'hBEEFBEEF, 2, 1);

      // Stray acks with no request outstanding must do nothing
      bus_ack   = 1'b1;
      bus_rdata = 32'h13572468;
      repeat (3) begin
         @(negedge clk);
         checkOutput("idleAck.bus_req", 32'(bus_req), 32'd0);
         checkOutput("idleAck.stall", 32'(stall), 32'd0);
      end
      @(posedge clk);
      #1;
      bus_ack = 1'b0;

      $display("[TB] bus timeout");
      applyStimulus("timeoutLoad", 1'b1, 1'b0, BHW_WORD, 1'b0, 32'h300, 32'h0, 32'hDEADBEEF, NO_ACK,
                    EV_BUSERR, 32'h0, 4'b1111, 32'h0, TIMEOUT + 1, TIMEOUT);

      $display("[TB] random loads");
      for (int i = 0; i < 6; i++) begin
         sz  = 2'($urandom_range(0, 3));
         off = 2'($urandom_range(0, 3));
         if (sz == BHW_HALF) off[0] = 1'b0;
         else if (sz[1]) off = 2'b00;
         sg = 1'($urandom_range(0, 1));
         w  = $urandom;
         a  = {18'd0, 12'($urandom_range(0, 4095)), off};
         aw = $urandom_range(0, 2);
         applyStimulus($sformatf("rndLoad%0d", i), 1'b1, 1'b0, sz, sg, a, 32'h0, w, aw,
                       EV_LOAD, refLoad(sz, off, sg, w), refBe(sz, off), 32'h0, 2 + aw, 1 + aw);
      end

      $display("[TB] reset during BUSY");
      mem_read  = 1'b1;
      mem_write = 1'b0;
      bhw       = BHW_WORD;
      ext_sign  = 1'b0;
      addr      = 32'h204;
      wdata     = 32'h0;
      repeat (2) @(negedge clk);
      checkOutput("rstMid.reqBefore", 32'(bus_req), 32'd1);
      checkOutput("rstMid.addrBefore", bus_addr, 32'h204);
      checkOutput("rstMid.beBefore", 32'(bus_be), 32'hF);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rstMid.bus_req", 32'(bus_req), 32'd0);
      checkOutput("rstMid.stall", 32'(stall), 32'd0);
      checkOutput("rstMid.bus_addr", bus_addr, 32'd0);
      @(negedge clk);
      checkOutput("rstHeld.stall", 32'(stall), 32'd0);
      checkOutput("rstHeld.bus_req", 32'(bus_req), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus("rstRetry", 1'b1, 1'b0, BHW_WORD, 1'b0, 32'h204, 32'h0, 32'hCAFEF00D, 0,
                    EV_LOAD, 32'hCAFEF00D, 4'b1111, 32'h0, 2, 1);

      repeat (3) @(negedge clk);
      checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the pipelined MIPS core. Takes the memory-control fields held in the EX/MEM pipeline register (read/write, byte/half/word size, sign-extend, address, store data). Runs a req/ack access on the external data-memory bus with lane steering and a timeout. Stalls the pipeline until the access completes, and returns aligned, extended load data toward MEM/WB.

## Interface
Parameters:
- TIMEOUT_CYC, default 64: max cycles bus_req stays high without bus_ack before a bus error; legal range 1..1023.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM.
- bhw  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- ext_sign  in  1  1 sign-extends loads, 0 zero-extends.
- addr  in  32  byte address (EX/MEM ALU result).
- wdata  in  32  store data (EX/MEM read-data-2).
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
- load_data  out  32  extended load result; valid when load_valid.
- load_valid  out  1  one-cycle pulse on load completion.
- align_err  out  1  one-cycle pulse: misaligned or illegal access.
- bus_err  out  1  one-cycle pulse: bus timeout.
- bus_req  out  1  access request, held until bus_ack or timeout.
- bus_we  out  1  1 write, 0 read.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian).
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  completion; sampled only while bus_req=1.
- bus_rdata  in  32  read word, valid with bus_ack.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Access present when mem_read|mem_write.
  - Both high is illegal: align_err pulse, no bus cycle, stall 0.
  - Misalignment rules: half needs addr[0]=0; word needs addr[1:0]=0. Misaligned access pulses align_err, starts no bus cycle, stall 0.
  - Legal access: stall=1 combinationally in the same cycle. Register bus_we/bus_addr/bus_be/bus_wdata, plus size, ext_sign and addr[1:0] for load extraction. Go to BUSY.
- BUSY:
  - bus_req=1, bus fields stable, stall=1, wait counter increments each cycle.
  - bus_ack=1 → capture extracted load data → DONE.
  - Counter reaches TIMEOUT_CYC without ack → drop bus_req, load_data=0 → DONE with bus_err pulse.
- DONE:
  - stall=0; load_valid=1 if the access was a read and no timeout occurred.
  - EX/MEM advances at the end of this cycle. Its still-visible request is ignored.
  - Unconditional return to IDLE.
- Lanes:
  - Byte: be=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Half: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - Word: be=1111.
  - Loads select the addressed lane, then extend to 32 bits per ext_sign.
- Reset (any time, including mid-BUSY):
  - State goes to IDLE immediately.
  - All outputs 0, including stall.
  - The interrupted access is abandoned. It is re-issued after release because EX/MEM still holds it.

## Timing
- Access presented in cycle 0; bus_req high from cycle 1.
- With ack in cycle 1+w (w wait cycles), DONE is cycle 2+w. stall is high for cycles 0..1+w (2+w cycles).
- Minimum stall: 2 cycles (ack in the first BUSY cycle).
- Timeout: bus_req high for exactly TIMEOUT_CYC cycles, then DONE with bus_err.
- align_err and bus_err are single-cycle pulses. load_data holds its value until the next load completes.
- bus_ack while bus_req=0 is ignored.

## Structure
- Shared package mips_mem_pkg holds:
  - BHW_BYTE, BHW_HALF, BHW_WORD encodings.
  - The mem_state_t enum (IDLE, BUSY, DONE).
- Sub-module mem_lane_align (combinational):
  - Store side: bus_be and store replication from size/addr[1:0].
  - Load side: lane extraction and extension from size/offset/ext_sign.
  - Instantiated once; the FSM, counter and registers stay in mem_stage_ctrl.

## Test plan
- Word store, addr 0x100, wdata 0xDEADBEEF, ack in first BUSY cycle → bus_we 1, bus_addr 0x100, bus_be 1111, stall 2 cycles, no load_valid.
- Signed byte load, addr 0x203, rdata 0x80FF1234 → bus_be 1000, load_data 0xFFFFFF80. Repeat with ext_sign 0 → 0x00000080.
- Unsigned half load, addr 0x206, rdata 0x80010000, ack after 3 wait cycles → bus_be 1100, load_data 0x00008001, stall 5 cycles.
- Word load at addr 0x102; then mem_read and mem_write both high → align_err pulse each time, bus_req never asserted, stall 0.
- TIMEOUT_CYC=4, load with ack never returned → bus_req high 4 cycles, then bus_err pulse, load_data 0, no load_valid, stall released.
- rst low during BUSY → bus_req and stall 0 immediately, FSM IDLE. After release, the held access re-issues with identical bus fields.
